// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, FSM state type and region decode for the IF stage.
package fetch_stage_pkg;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [31:0] NOP_INST_DEF = {25'd0, OPC_OP_IMM};
  localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
  localparam logic [3:0] BIOS_NIB = 4'h4;
  localparam logic [3:0] IMEM_NIB = 4'h1;
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} fetch_state_e;
  function automatic logic in_bios(input logic [31:0] pc);
    return pc[31:28] == BIOS_NIB;
  endfunction
endpackage

// File: rtl/fetch_stage_pc_next_gen.sv
// pc_next_gen: combinational next-PC selection and BIOS/IMEM source decode.
module pc_next_gen
  import fetch_stage_pkg::*;
(
  input  logic        boot,
  input  logic        pc_sel,
  input  logic [31:0] redirect_pc,
  input  logic        if_stall,
  input  logic [31:0] pc_f,
  output logic [31:0] next_pc,
  output logic        src_bios
);
  always_comb begin
    next_pc = boot ? pc_f : pc_sel ? (redirect_pc & ~32'h3) : if_stall ? pc_f : pc_f + 32'd4;
    src_bios = in_bios(next_pc);
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the PC, BRAM read addressing and the IF/DX register.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_sel,
  input  logic [31:0]        redirect_pc,
  input  logic               if_flush,
  input  logic               if_stall,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [31:0]        bios_dout,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        inst_DX,
  output logic [31:0]        pc_DX,
  output logic               valid_DX,
  output logic [31:0]        fetch_count,
  output logic [31:0]        flush_count
);
  fetch_state_e state, state_nx;
  logic [31:0] pc_f, next_pc, inst_f;
  logic src_bios, src_sel_q, boot, squash, load;
  assign boot = state == BOOT;
  pc_next_gen u_pc_next_gen (
    .boot       (boot),
    .pc_sel     (pc_sel),
    .redirect_pc(redirect_pc),
    .if_stall   (if_stall),
    .pc_f       (pc_f),
    .next_pc    (next_pc),
    .src_bios   (src_bios)
  );
  // Addresses come from next_pc so the BRAM word for pc_f is ready while pc_f is current.
  assign bios_addr = next_pc[BIOS_AW+1:2];
  assign imem_addr = next_pc[IMEM_AW+1:2];
  assign inst_f = src_sel_q ? bios_dout : imem_dout;
  always_comb begin
    state_nx = RUN;
    squash = !boot && (if_flush || pc_sel);
    load = !boot && !squash && !if_stall;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_f <= RESET_PC;
      src_sel_q <= 1'b1;
      inst_DX <= NOP_INST;
      pc_DX <= RESET_PC;
      valid_DX <= 1'b0;
    end else begin
      state <= state_nx;
      pc_f <= next_pc;
      src_sel_q <= src_bios;
      if (boot || squash) begin
        inst_DX <= NOP_INST;
        pc_DX <= pc_f;
        valid_DX <= 1'b0;
      end else if (load) begin
        inst_DX <= inst_f;
        pc_DX <= pc_f;
        valid_DX <= 1'b1;
      end
    end
  end
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_q, flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      flush_q <= '0;
    end else begin
      if (load) fetch_q <= fetch_q + 32'd1;
      if (squash) flush_q <= flush_q + 32'd1;
    end
  end
  assign fetch_count = fetch_q;
  assign flush_count = flush_q;
`else
  assign fetch_count = '0;
  assign flush_count = '0;
`endif
endmodule
